// File: rtl/dmem_responder_if.sv
// DMEM port bundle between the pipelined core (master) and the data memory (slave).
// Signal names follow the core's DMEM port naming.
`timescale 1ns/1ps
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] DIR_DMEM;
    logic [DATA_W-1:0] DATA_WRITE_DMEM;
    logic              READ;
    logic              WRITE;
    logic [DATA_W-1:0] DATA_READ_DMEM;
    logic              READY;

    modport master (
        output DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
        input  DATA_READ_DMEM, READY
    );

    modport slave (
        input  DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
        output DATA_READ_DMEM, READY
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target for the core's DMEM port: word RAM with 1-cycle registered read and a post-reset clear.
// Optional MMIO output register at the top address, enabled by defining DMEM_MMIO_EN.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    dmem_responder_if.slave   bus
`ifdef DMEM_MMIO_EN
    ,
    output logic [DATA_W-1:0] GPIO_OUT
`endif
);
    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we_c;
    logic [CNT_W-1:0]  mem_idx_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic              in_range_c;
    logic              mmio_hit_c;
    logic              arr_hit_c;
    logic [CNT_W-1:0]  addr_idx_c;

    assign in_range_c = ((ADDR_W+1)'(bus.DIR_DMEM) < DEPTH_LIM);
    assign addr_idx_c = CNT_W'(bus.DIR_DMEM);
    assign arr_hit_c  = in_range_c && !mmio_hit_c;

`ifdef DMEM_MMIO_EN
    logic [DATA_W-1:0] gpio_q, gpio_d;

    // Top address is carved out of the array for the output register.
    assign mmio_hit_c = (bus.DIR_DMEM == {ADDR_W{1'b1}});
    assign GPIO_OUT   = gpio_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_d;
        end
    end
`else
    assign mmio_hit_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Next state: sweep every word once, then serve requests until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    // Outputs and array write port; write-first on a same-cycle read.
    always_comb begin
        ready_d     = (state_d == ST_RUN);
        rdata_d     = rdata_q;
        mem_we_c    = 1'b0;
        mem_idx_c   = cnt_q;
        mem_wdata_c = '0;
`ifdef DMEM_MMIO_EN
        gpio_d      = gpio_q;
`endif
        if (state_q == ST_INIT) begin
            mem_we_c = 1'b1;
        end else begin
            if (bus.WRITE && arr_hit_c) begin
                mem_we_c    = 1'b1;
                mem_idx_c   = addr_idx_c;
                mem_wdata_c = bus.DATA_WRITE_DMEM;
            end
`ifdef DMEM_MMIO_EN
            if (bus.WRITE && mmio_hit_c) begin
                gpio_d = bus.DATA_WRITE_DMEM;
            end
`endif
            if (bus.READ) begin
                if (arr_hit_c) begin
                    rdata_d = bus.WRITE ? bus.DATA_WRITE_DMEM : mem_q[addr_idx_c];
                end else if (mmio_hit_c) begin
`ifdef DMEM_MMIO_EN
                    rdata_d = bus.WRITE ? bus.DATA_WRITE_DMEM : gpio_q;
`else
                    rdata_d = '0;
`endif
                end else begin
                    rdata_d = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem_q[mem_idx_c] <= mem_wdata_c;
        end
    end

    assign bus.DATA_READ_DMEM = rdata_q;
    assign bus.READY          = ready_q;
endmodule
